// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// Imported by ps2_host_tx and ps2_sync_edge.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAITIDLE,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // 100 us inhibit and 2 ms inter-edge timeout at 24 MHz
  localparam int DEF_INHIBIT_CYCLES = 2400;
  localparam int DEF_TIMEOUT_CYCLES = 48000;

  function automatic logic [9:0] frame_bits(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a PS/2 pin with falling-edge detect.
// Resets to the idle (released, high) line level.
module ps2_sync_edge
  import ps2_host_tx_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta  <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
    end else begin
      meta  <= pin;
      level <= meta;
      prev  <= level;
    end
  end

  assign fall = prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send,
// device-clocked 11-bit frame, then ACK check, via open-collector enables.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAXC = (INHIBIT_CYCLES > TIMEOUT_CYCLES)
                      ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_MAX   = CW'(TIMEOUT_CYCLES);

  state_t        state;
  state_t        next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [9:0]    shreg;
  logic [3:0]    bitcnt;
  logic          line_bit;
  logic          expired;
  logic          watch;
  logic          clk_s;
  logic          clk_fall;
  logic          data_s;

  ps2_sync_edge u_clk_sync (
    .clk   (CLK),
    .reset (RESET),
    .pin   (ps2_clk_in),
    .level (clk_s),
    .fall  (clk_fall)
  );

  ps2_sync_edge u_data_sync (
    .clk   (CLK),
    .reset (RESET),
    .pin   (ps2_data_in),
    .level (data_s),
    .fall  ()
  );

  assign watch   = (state == SHIFT) || (state == ACK)
                || (state == WAITIDLE);
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:     if (tx_start) next = INHIBIT;
      INHIBIT:  if (cnt == INH_LAST) next = REQ;
      REQ:      next = SHIFT;
      SHIFT: begin
        if (expired) next = ERR;
        else if (clk_fall && bitcnt == 4'd10) next = ACK;
      end
      ACK: begin
        if (expired) next = ERR;
        else if (clk_fall) next = data_s ? ERR : WAITIDLE;
      end
      WAITIDLE: begin
        if (expired) next = ERR;
        else if (clk_s && data_s) next = DONE;
      end
      DONE:     next = IDLE;
      ERR:      next = IDLE;
      default:  next = IDLE;
    endcase
  end

  // Timeout is flagged one cycle after the count reaches its limit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt      <= '0;
      shreg    <= '0;
      bitcnt   <= '0;
      line_bit <= 1'b0;
      expired  <= 1'b0;
    end else begin
      expired <= watch && !clk_fall && (cnt == TO_MAX);
      unique case (state)
        IDLE: begin
          cnt      <= '0;
          bitcnt   <= '0;
          line_bit <= 1'b0;
          if (tx_start) shreg <= frame_bits(tx_data);
        end
        INHIBIT: cnt <= cnt_inc;
        REQ:     cnt <= '0;
        SHIFT, ACK, WAITIDLE: begin
          cnt <= clk_fall ? '0 : cnt_inc;
          if (state == SHIFT && clk_fall && bitcnt != 4'd10) begin
            line_bit <= shreg[0];
            shreg    <= {1'b0, shreg[9:1]};
            bitcnt   <= bitcnt + 4'd1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    tx_busy     = 1'b1;
    tx_done     = 1'b0;
    tx_error    = 1'b0;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    unique case (state)
      IDLE:    tx_busy = 1'b0;
      INHIBIT: ps2_clk_oe = 1'b1;
      REQ:     ps2_data_oe = 1'b1;
      SHIFT:   ps2_data_oe = ~line_bit;
      DONE: begin
        tx_busy = 1'b0;
        tx_done = 1'b1;
      end
      ERR: begin
        tx_busy  = 1'b0;
        tx_error = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device on open-collector
// pins receives frames and ACKs; results are checked against a model.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INH = 40;
  localparam int TO  = 300;
  localparam int H   = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error;
  logic       clk_oe, data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       clk_pin, data_pin;

  assign clk_pin  = ~(clk_oe | dev_clk_low);
  assign data_pin = ~(data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK         (clk),
    .RESET       (rst),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .ps2_clk_in  (clk_pin),
    .ps2_data_in (data_pin),
    .ps2_clk_oe  (clk_oe),
    .ps2_data_oe (data_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_done = 0;
  int n_err = 0;
  int checks = 0;
  int fails = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (tx_done)  n_done++;
    if (tx_error) n_err++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] model_frame(input logic [7:0] d);
    logic par;
    par = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, d};
  endfunction

  // Device: waits for request-to-send, clocks 12 falls, samples on rise.
  task automatic device(input int stop_after, input bit ack,
                        output logic [9:0] bits, output bit ok);
    int w;
    bits = '0;
    ok = 1'b0;
    w = 0;
    while (!(data_pin === 1'b0 && clk_pin === 1'b1) && w < INH + 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= INH + 100) return;
    ok = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b1;
      if (k == stop_after) begin
        repeat (H / 2) @(negedge clk);
        return;
      end
      repeat (H) @(negedge clk);
      if (k <= 10) bits[k-1] = data_pin;
      if (k == 11 && ack) dev_data_low = 1'b1;
      dev_clk_low = 1'b0;
    end
    repeat (H) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic start(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data = 8'($urandom);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (tx_busy && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("idle_wait", 32'(w < 2000), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack,
                           input bit poke, output logic [9:0] bits,
                           output int dn, output int er);
    int d0, e0;
    bit ok;
    d0 = n_done;
    e0 = n_err;
    start(d);
    if (poke) begin
      repeat (5) @(negedge clk);
      tx_data = 8'hAA;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
    end
    device(99, ack, bits, ok);
    check("req_seen", 32'(ok), 32'd1);
    wait_idle();
    dn = n_done - d0;
    er = n_err - e0;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         poke;
    logic       par;
    int         dn;
    int         er;
  } vec_t;

  vec_t       tbl [6];
  logic [9:0] bits;
  logic [9:0] exp_f;
  int         dn, er, w, r, d0, e0;
  bit         ok, ack;
  logic [7:0] d;

  initial begin
    tbl[0] = '{8'hED, 1'b1, 1'b0, 1'b1, 1, 0};
    tbl[1] = '{8'h00, 1'b1, 1'b0, 1'b1, 1, 0};
    tbl[2] = '{8'h07, 1'b1, 1'b0, 1'b0, 1, 0};
    tbl[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1, 0};
    tbl[4] = '{8'h55, 1'b0, 1'b0, 1'b1, 0, 1};
    tbl[5] = '{8'hF4, 1'b1, 1'b0, 1'b0, 1, 0};

    repeat (4) @(negedge clk);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_error", 32'(tx_error), 32'd0);
    check("rst_clk_oe", 32'(clk_oe), 32'd0);
    check("rst_data_oe", 32'(data_oe), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Acceptance and inhibit latency
    d0 = n_done;
    start(CMD_SET_LEDS);
    check("start_busy", 32'(tx_busy), 32'd1);
    check("start_clk_oe", 32'(clk_oe), 32'd1);
    check("start_data_oe", 32'(data_oe), 32'd0);
    w = 0;
    while (!data_oe && w < INH + 10) begin
      @(negedge clk);
      w++;
    end
    check("inhibit_len", 32'(w), 32'(INH));
    check("req_clk_oe", 32'(clk_oe), 32'd0);
    device(99, 1'b1, bits, ok);
    wait_idle();
    check("lat_frame", 32'(bits), 32'(model_frame(CMD_SET_LEDS)));
    check("lat_done", 32'(n_done - d0), 32'd1);

    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].data, tbl[i].ack, tbl[i].poke, bits, dn, er);
      check($sformatf("tbl%0d_data", i), 32'(bits[7:0]), 32'(tbl[i].data));
      check($sformatf("tbl%0d_parity", i), 32'(bits[8]), 32'(tbl[i].par));
      check($sformatf("tbl%0d_stop", i), 32'(bits[9]), 32'd1);
      check($sformatf("tbl%0d_done", i), 32'(dn), 32'(tbl[i].dn));
      check($sformatf("tbl%0d_error", i), 32'(er), 32'(tbl[i].er));
    end

    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      ack = ($urandom_range(0, 4) != 0);
      exp_f = model_frame(d);
      run_frame(d, ack, 1'b0, bits, dn, er);
      check($sformatf("rnd%0d_frame", i), 32'(bits), 32'(exp_f));
      check($sformatf("rnd%0d_done", i), 32'(dn), ack ? 32'd1 : 32'd0);
      check($sformatf("rnd%0d_error", i), 32'(er), ack ? 32'd0 : 32'd1);
    end

    // Device never clocks: timeout measured from the REQ cycle
    d0 = n_done;
    e0 = n_err;
    start(8'h3C);
    w = 0;
    while (!data_oe && w < INH + 10) begin
      @(negedge clk);
      w++;
    end
    r = cyc;
    w = 0;
    while (!tx_error && w < TO + 50) begin
      @(negedge clk);
      w++;
    end
    check("timeout_lat", 32'(cyc - r), 32'(TO + 3));
    @(negedge clk);
    check("timeout_clk_oe", 32'(clk_oe), 32'd0);
    check("timeout_data_oe", 32'(data_oe), 32'd0);
    check("timeout_err_cnt", 32'(n_err - e0), 32'd1);
    check("timeout_done_cnt", 32'(n_done - d0), 32'd0);
    repeat (4) @(negedge clk);

    // Reset during the 5th data bit
    d0 = n_done;
    e0 = n_err;
    start(8'h96);
    device(5, 1'b1, bits, ok);
    check("rst_mid_req", 32'(ok), 32'd1);
    check("rst_mid_pre_busy", 32'(tx_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_clk_oe", 32'(clk_oe), 32'd0);
    check("rst_mid_data_oe", 32'(data_oe), 32'd0);
    check("rst_mid_busy", 32'(tx_busy), 32'd0);
    rst = 1'b0;
    dev_clk_low = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_mid_no_done", 32'(n_done - d0), 32'd0);
    check("rst_mid_no_error", 32'(n_err - e0), 32'd0);
    run_frame(CMD_ENABLE, 1'b1, 1'b0, bits, dn, er);
    check("post_rst_frame", 32'(bits), 32'(model_frame(CMD_ENABLE)));
    check("post_rst_done", 32'(dn), 32'd1);
    check("post_rst_error", 32'(er), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
